// File: rtl/tff_mod_counter_pkg.sv
// Shared constants and helpers for the toggle-flop modulo counter.
// Direction encodings and a clog2 helper for callers sizing WIDTH from MOD.
package tff_mod_counter_pkg;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/tff_mod_counter_cell.sv
// Single toggle flop: flips on T, synchronous active-high reset to RST_BIT.
module tff_cell #(
    parameter logic RST_BIT = 1'b0
) (
    input  logic CLK,
    input  logic RST,
    input  logic T,
    output logic Q
);

    logic q_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            q_q <= RST_BIT;
        end else if (T) begin
            q_q <= ~q_q;
        end
    end

    assign Q = q_q;

endmodule

// File: rtl/tff_mod_counter.sv
// Modulo-MOD counter built from WIDTH toggle cells, with load, carry and sticky wrap.
// Define TFF_MOD_COUNTER_UPDOWN_EN to honour DIR; otherwise the counter is up-only.
module tff_mod_counter
    import tff_mod_counter_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int MOD       = 10,
    parameter int RESET_VAL = 0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic             LD,
    input  logic [WIDTH-1:0] LD_VAL,
    input  logic             DIR,
    input  logic             CLR_OVF,
    output logic [WIDTH-1:0] Q,
    output logic             TC,
    output logic             OVF
);

    if (MOD < 2 || MOD > (1 << WIDTH)) begin : g_bad_mod
        $error("tff_mod_counter: MOD must be in 2..2**WIDTH");
    end
    if (RESET_VAL < 0 || RESET_VAL >= MOD) begin : g_bad_rst
        $error("tff_mod_counter: RESET_VAL must be below MOD");
    end

    localparam logic [WIDTH-1:0] TERM_UP = WIDTH'(MOD - 1);
    localparam logic [WIDTH:0]   MOD_X   = (WIDTH + 1)'(MOD);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;
    logic [WIDTH-1:0] step;
    logic [WIDTH-1:0] ld_clamp;
    logic [WIDTH-1:0] tog;
    logic             at_term;
    logic             wrap;
    logic             ovf_q;
    logic             ovf_d;

`ifndef TFF_MOD_COUNTER_UPDOWN_EN
    logic unused_dir;
    assign unused_dir = DIR;
`endif

    always_comb begin
        at_term = (cnt_q == TERM_UP);
        step    = at_term ? '0 : cnt_q + WIDTH'(1);
`ifdef TFF_MOD_COUNTER_UPDOWN_EN
        if (DIR == DIR_DOWN) begin
            at_term = (cnt_q == '0);
            step    = at_term ? TERM_UP : cnt_q - WIDTH'(1);
        end
`endif
    end

    // Out-of-range loads saturate to the top legal count.
    assign ld_clamp = ({1'b0, LD_VAL} < MOD_X) ? LD_VAL : TERM_UP;

    always_comb begin
        cnt_d = cnt_q;
        if (LD) begin
            cnt_d = ld_clamp;
        end else if (EN) begin
            cnt_d = step;
        end
    end

    assign tog = cnt_d ^ cnt_q;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        tff_cell #(
            .RST_BIT(1'((RESET_VAL >> i) & 1))
        ) u_cell (
            .CLK(CLK),
            .RST(RST),
            .T  (tog[i]),
            .Q  (cnt_q[i])
        );
    end

    assign wrap = EN & ~LD & at_term;

    // A wrap on the same edge as CLR_OVF keeps the flag set.
    always_comb begin
        ovf_d = ovf_q;
        if (wrap) begin
            ovf_d = 1'b1;
        end else if (CLR_OVF) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign Q   = cnt_q;
    assign TC  = EN & at_term;
    assign OVF = ovf_q;

endmodule

// File: tb/tb_tff_mod_counter.sv
// Bench for tff_mod_counter: modular-arithmetic model plus directed literal checks.
module tb_tff_mod_counter;

    localparam int MA  = 10;
    localparam int RVA = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Main instance
    logic       rst = 1'b1, en = 1'b0, ld = 1'b0, dir = 1'b0, clr = 1'b0;
    logic [3:0] ld_val = '0;
    logic [3:0] q;
    logic       tc, ovf;

    tff_mod_counter #(.WIDTH(4), .MOD(MA), .RESET_VAL(RVA)) u_a (
        .CLK(clk), .RST(rst), .EN(en), .LD(ld), .LD_VAL(ld_val),
        .DIR(dir), .CLR_OVF(clr), .Q(q), .TC(tc), .OVF(ovf)
    );

    // Two-stage decimal cascade
    logic       c_rst = 1'b1, c_en = 1'b0;
    logic [3:0] q0, q1;
    logic       tc0, tc1, ovf0, ovf1;

    tff_mod_counter #(.WIDTH(4), .MOD(10), .RESET_VAL(0)) u_c0 (
        .CLK(clk), .RST(c_rst), .EN(c_en), .LD(1'b0), .LD_VAL(4'd0),
        .DIR(1'b0), .CLR_OVF(1'b0), .Q(q0), .TC(tc0), .OVF(ovf0)
    );
    tff_mod_counter #(.WIDTH(4), .MOD(10), .RESET_VAL(0)) u_c1 (
        .CLK(clk), .RST(c_rst), .EN(tc0), .LD(1'b0), .LD_VAL(4'd0),
        .DIR(1'b0), .CLR_OVF(1'b0), .Q(q1), .TC(tc1), .OVF(ovf1)
    );

    // Full binary range instance
    logic       h_rst = 1'b1, h_en = 1'b0, h_ld = 1'b0;
    logic [3:0] h_ld_val = '0;
    logic [3:0] h_q;
    logic       h_tc, h_ovf;

    tff_mod_counter #(.WIDTH(4), .MOD(16), .RESET_VAL(0)) u_h (
        .CLK(clk), .RST(h_rst), .EN(h_en), .LD(h_ld), .LD_VAL(h_ld_val),
        .DIR(1'b0), .CLR_OVF(1'b0), .Q(h_q), .TC(h_tc), .OVF(h_ovf)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: counts as integers modulo MOD
    logic m_down;
`ifdef TFF_MOD_COUNTER_UPDOWN_EN
    assign m_down = dir;
`else
    assign m_down = 1'b0;
`endif

    int m_q = 0;
    bit m_ovf = 0;
    bit m_valid = 0;
    int c_cnt = 0;
    bit c_valid = 0;

    always @(posedge clk) begin
        bit w;
        w = 0;
        if (rst) begin
            m_q = RVA;
            m_ovf = 0;
            m_valid = 1;
        end else if (m_valid) begin
            if (ld) begin
                m_q = (int'(ld_val) < MA) ? int'(ld_val) : MA - 1;
            end else if (en) begin
                if (m_down) begin
                    w = (m_q == 0);
                    m_q = (m_q + MA - 1) % MA;
                end else begin
                    w = (m_q == MA - 1);
                    m_q = (m_q + 1) % MA;
                end
            end
            if (w) m_ovf = 1;
            else if (clr) m_ovf = 0;
        end
        if (c_rst) begin
            c_cnt = 0;
            c_valid = 1;
        end else if (c_valid && c_en) begin
            c_cnt = (c_cnt + 1) % 100;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("a_q", q, m_q);
            chk("a_ovf", ovf, m_ovf);
            chk("a_tc", tc, en && (m_q == (m_down ? 0 : MA - 1)));
        end
        if (c_valid) begin
            chk("casc_cnt", int'(q1) * 10 + int'(q0), c_cnt);
            chk("casc_tc0", tc0, c_en && (c_cnt % 10 == 9));
            chk("casc_tc1", tc1, c_en && (c_cnt == 99));
        end
    end

    initial begin
        // Reset, then run into a wrap and reset again with LD asserted
        tick();
        chk("reset_q", q, 3);
        chk("reset_ovf", ovf, 0);
        rst = 0;
        en = 1;
        repeat (7) tick();
        chk("prerst_q", q, 0);
        chk("prerst_ovf", ovf, 1);
        rst = 1; ld = 1; ld_val = 7;
        tick();
        chk("rst_ld_q", q, 3);
        chk("rst_ld_ovf", ovf, 0);
        rst = 0; ld = 0; en = 0;

        // Up count 0..9,0
        ld = 1; ld_val = 0;
        tick();
        ld = 0; en = 1;
        for (int k = 1; k <= 10; k++) begin
            if (k == 10) chk("up_tc9", tc, 1);
            tick();
            chk("up_q", q, k % 10);
            chk("up_ovf", ovf, (k == 10) ? 1 : 0);
        end

        // Down wrap from 1
        en = 0; clr = 1;
        tick();
        clr = 0; ld = 1; ld_val = 1;
        tick();
        ld = 0; en = 1; dir = 1;
        tick();
`ifdef TFF_MOD_COUNTER_UPDOWN_EN
        chk("dn_q0", q, 0);
        chk("dn_tc0", tc, 1);
        tick();
        chk("dn_q9", q, 9);
        chk("dn_ovf", ovf, 1);
`else
        chk("dn_q2", q, 2);
        chk("dn_tc", tc, 0);
        tick();
        chk("dn_q3", q, 3);
        chk("dn_ovf", ovf, 0);
`endif

        // Load clamp and priority over EN
        dir = 0; en = 0; clr = 1;
        tick();
        clr = 0; ld = 1; ld_val = 9;
        tick();
        chk("ld9_q", q, 9);
        en = 1; ld_val = 14;
        tick();
        chk("clamp_q", q, 9);
        chk("clamp_ovf", ovf, 0);
        ld_val = 5;
        tick();
        chk("ld5_q", q, 5);
        chk("ld5_ovf", ovf, 0);

        // Wrap vs CLR_OVF on the same edge
        ld_val = 9;
        tick();
        ld = 0; clr = 1;
        tick();
        chk("race_q", q, 0);
        chk("race_ovf", ovf, 1);
        en = 0;
        tick();
        chk("clr_ovf", ovf, 0);
        clr = 0;

        // Mixed directed/random traffic, checked by the model
        repeat (60) begin
            en = 1'($urandom);
            ld = ($urandom_range(0, 3) == 0);
            ld_val = 4'($urandom);
            dir = 1'($urandom);
            clr = ($urandom_range(0, 7) == 0);
            tick();
        end
        en = 0; ld = 0; clr = 0; dir = 0;

        // Cascade 00..99,00
        c_rst = 0; c_en = 1;
        for (int k = 1; k <= 100; k++) begin
            tick();
            chk("casc_step", int'(q1) * 10 + int'(q0), k % 100);
        end
        chk("casc_ovf0", ovf0, 1);
        chk("casc_ovf1", ovf1, 1);
        c_en = 0;

        // Binary roll-over at 2**WIDTH
        h_rst = 0; h_ld = 1; h_ld_val = 14;
        tick();
        h_ld = 0; h_en = 1;
        chk("h_q14", h_q, 14);
        chk("h_tc14", h_tc, 0);
        tick();
        chk("h_q15", h_q, 15);
        chk("h_tc15", h_tc, 1);
        tick();
        chk("h_q0", h_q, 0);
        chk("h_ovf", h_ovf, 1);
        h_en = 0;

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
